// File: rtl/eval_sram_to_sram_mul_seq_if.sv
// Control/status and SRAM-side bundle for the SRAM-to-SRAM multiply sequencer.
// Latency: none, wires only.
// Backpressure: none; the sequencer streams one element per cycle unconditionally.
interface eval_sram_to_sram_mul_seq_if #(
    parameter int ADDR_BITS = 9,
    parameter int CNT_BITS  = 32
);
    logic                 start;
    logic                 abort;
    logic [ADDR_BITS:0]   len;
    logic                 busy;
    logic                 done;
    logic                 src_re;
    logic [ADDR_BITS-1:0] src_addr;
    logic                 dst_we;
    logic [ADDR_BITS-1:0] dst_addr;
    logic [CNT_BITS-1:0]  cycles;

    // Requester side: issues runs and observes the traffic.
    modport master (
        output start, abort, len,
        input  busy, done, src_re, src_addr, dst_we, dst_addr, cycles
    );

    // Sequencer side.
    modport slave (
        input  start, abort, len,
        output busy, done, src_re, src_addr, dst_we, dst_addr, cycles
    );
endinterface

// File: rtl/eval_sram_to_sram_mul_seq.sv
// Streams len source-SRAM reads and the matching destination writes through a read+multiply delay line.
// Latency: first dst_we RD_LATENCY+MUL_LATENCY cycles after first src_re; done one cycle after last dst_we.
// Backpressure: none; abort cancels synchronously. Optional cycle counter under EVAL_SEQ_CYCLE_COUNTER_EN.
module eval_sram_to_sram_mul_seq #(
    parameter int ADDR_BITS   = 9,
    parameter int RD_LATENCY  = 1,
    parameter int MUL_LATENCY = 3,
    parameter int CNT_BITS    = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    eval_sram_to_sram_mul_seq_if.slave  bus
);

    localparam int DLY = RD_LATENCY + MUL_LATENCY;
    localparam logic [ADDR_BITS:0] LEN_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   len_q, len_d;

    // Delay line: valid bit plus address per stage; the last stage is the write port.
    logic [DLY-1:0]       dly_vld_q;
    logic [ADDR_BITS-1:0] dly_addr_q [DLY];

    logic                 src_re;
    logic [ADDR_BITS-1:0] src_addr;
    logic                 last_rd;
    logic                 dly_pending;
    logic                 accept;
    logic                 flush;

    // Read port and run bookkeeping decoded from the current state.
    always_comb begin
        src_re   = (state_q == RUN);
        src_addr = src_re ? addr_q : '0;
        last_rd  = ({1'b0, addr_q} == (len_q - LEN_ONE));
        accept   = (state_q == IDLE) && bus.start && !bus.abort;
    end

    // Anything still in flight ahead of the final stage keeps us in DRAIN.
    always_comb begin
        dly_pending = 1'b0;
        for (int i = 0; i < DLY - 1; i++) begin
            dly_pending = dly_pending | dly_vld_q[i];
        end
    end

    // Next-state logic: abort beats everything outside IDLE, start only counts in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        len_d   = bus.len;
                        addr_d  = '0;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    flush   = 1'b1;
                end else if (last_rd) begin
                    // Stop here so a full-size run never wraps the address.
                    state_d = DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (!dly_pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address and length registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    // Read-to-write delay line; an abort empties it so no stale write escapes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dly_vld_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                dly_addr_q[i] <= '0;
            end
        end else if (flush) begin
            dly_vld_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                dly_addr_q[i] <= '0;
            end
        end else begin
            dly_vld_q[0]  <= src_re;
            dly_addr_q[0] <= src_addr;
            for (int i = 1; i < DLY; i++) begin
                dly_vld_q[i]  <= dly_vld_q[i-1];
                dly_addr_q[i] <= dly_addr_q[i-1];
            end
        end
    end

    // Status and write-port outputs; an abort landing in DONE suppresses the pulse.
    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == DONE) && !bus.abort;
        bus.src_re   = src_re;
        bus.src_addr = src_addr;
        bus.dst_we   = dly_vld_q[DLY-1];
        bus.dst_addr = dly_vld_q[DLY-1] ? dly_addr_q[DLY-1] : '0;
    end

`ifdef EVAL_SEQ_CYCLE_COUNTER_EN
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] cycles_q, cycles_d;

    // Count from the accepting cycle through the done cycle inclusive.
    always_comb begin
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = CNT_BITS'(1);
                end
            end
            RUN, DRAIN: begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
            DONE: begin
                if (!bus.abort) begin
                    cycles_d = cnt_q + CNT_BITS'(1);
                end
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Counter registers; cycles only changes on a completed run.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign bus.cycles = cycles_q;
`else
    assign bus.cycles = '0;
`endif

endmodule

// File: tb/tb_eval_sram_to_sram_mul_seq.sv
// Bench for the SRAM-to-SRAM multiply sequencer: per-cycle model compare plus directed literal checks.
// Latency: model predicts each output from cycles elapsed since the accepted start.
// Backpressure: none; stimulus drives start/abort/len freely, including illegal-time starts.
module tb_eval_sram_to_sram_mul_seq;

    localparam int AB   = 9;
    localparam int RDL  = 1;
    localparam int MULL = 3;
    localparam int CB   = 32;
    localparam int D    = RDL + MULL;
`ifdef EVAL_SEQ_CYCLE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    eval_sram_to_sram_mul_seq_if #(.ADDR_BITS(AB), .CNT_BITS(CB)) bus ();

    eval_sram_to_sram_mul_seq #(
        .ADDR_BITS  (AB),
        .RD_LATENCY (RDL),
        .MUL_LATENCY(MULL),
        .CNT_BITS   (CB)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is described only by its length and how many cycles ago it was accepted.
    bit     m_active = 1'b0;
    int     m_rel    = 0;
    int     m_len    = 0;
    longint m_cycles = 0;

    function automatic int done_rel(input int l);
        return (l == 0) ? 1 : l + D + 1;
    endfunction

    always @(negedge aresetn) begin
        m_active = 1'b0;
        m_cycles = 0;
    end

    always @(posedge aclk) begin
        if (aresetn) begin
            if (m_active) begin
                if (bus.abort) begin
                    m_active = 1'b0;
                end else if (m_rel == done_rel(m_len)) begin
                    m_cycles = CNT_EN ? longint'(done_rel(m_len) + 1) : 0;
                    m_active = 1'b0;
                end else begin
                    m_rel++;
                end
            end else if (bus.start && !bus.abort) begin
                // abort wins over a simultaneous start
                m_active = 1'b1;
                m_rel    = 1;
                m_len    = int'(bus.len);
            end
        end
    end

    // Per-cycle compare against the model, on the falling edge.
    always @(negedge aclk) begin
        bit e_rd, e_wr;
        e_rd = m_active && (m_rel <= m_len);
        e_wr = m_active && (m_rel > D) && (m_rel <= m_len + D);
        check("busy",     longint'(bus.busy),     longint'(m_active));
        check("done",     longint'(bus.done),
              longint'(m_active && m_rel == done_rel(m_len) && !bus.abort));
        check("src_re",   longint'(bus.src_re),   longint'(e_rd));
        check("src_addr", longint'(bus.src_addr), e_rd ? longint'((m_rel - 1) % (1 << AB)) : 0);
        check("dst_we",   longint'(bus.dst_we),   longint'(e_wr));
        check("dst_addr", longint'(bus.dst_addr), e_wr ? longint'((m_rel - 1 - D) % (1 << AB)) : 0);
        check("cycles",   longint'(bus.cycles),   m_cycles);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (bus.busy && i < 3000) begin
            tick();
            i++;
        end
        check("idle_timeout", longint'(bus.busy), 0);
    endtask

    // Launch one run and record what the traffic looked like, relative to the start cycle.
    task automatic observe_run(input int l, input int abort_rel, input int start_rel,
                               output int n_rd, output int n_wr, output int first_rd,
                               output int first_wr, output int d_rel, output int last_addr,
                               output int last_busy);
        int r;
        n_rd = 0; n_wr = 0; first_rd = 0; first_wr = 0; d_rel = 0; last_addr = -1; last_busy = 0;
        bus.len   = (AB+1)'(l);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (r = 1; r < 2000; r++) begin
            bus.start = (r == start_rel);
            bus.abort = (r == abort_rel);
            if (r == start_rel) bus.len = (AB+1)'(3);
            #1;
            if (bus.busy) last_busy = r;
            if (bus.src_re) begin
                n_rd++;
                if (first_rd == 0) first_rd = r;
                last_addr = int'(bus.src_addr);
            end
            if (bus.dst_we) begin
                n_wr++;
                if (first_wr == 0) first_wr = r;
            end
            if (bus.done) d_rel = r;
            @(posedge aclk);
            #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (!bus.busy) break;
        end
        check("run_bounded", longint'(bus.busy), 0);
    endtask

    initial begin
        int n_rd, n_wr, f_rd, f_wr, d_rel, l_addr, l_busy;
        int l;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len   = '0;
        repeat (3) tick();
        check("rst_busy",   longint'(bus.busy), 0);
        check("rst_src_re", longint'(bus.src_re), 0);
        check("rst_cycles", longint'(bus.cycles), 0);
        aresetn = 1'b1;
        tick();

        // len=4: reads on rel 1..4, writes on 5..8, done on 9.
        observe_run(4, 0, 0, n_rd, n_wr, f_rd, f_wr, d_rel, l_addr, l_busy);
        check("l4_n_rd",    n_rd, 4);
        check("l4_first_rd", f_rd, 1);
        check("l4_last_addr", l_addr, 3);
        check("l4_n_wr",    n_wr, 4);
        check("l4_first_wr", f_wr, 5);
        check("l4_done_rel", d_rel, 9);
        check("l4_cycles",  longint'(bus.cycles), CNT_EN ? 10 : 0);

        // len=0: done next cycle, no traffic, busy one cycle.
        observe_run(0, 0, 0, n_rd, n_wr, f_rd, f_wr, d_rel, l_addr, l_busy);
        check("l0_n_rd",    n_rd, 0);
        check("l0_n_wr",    n_wr, 0);
        check("l0_done_rel", d_rel, 1);
        check("l0_busy_len", l_busy, 1);
        check("l0_cycles",  longint'(bus.cycles), CNT_EN ? 2 : 0);

        // Full SRAM: 512 reads ending at 511, 512 writes, no wrap.
        observe_run(512, 0, 0, n_rd, n_wr, f_rd, f_wr, d_rel, l_addr, l_busy);
        check("l512_n_rd",   n_rd, 512);
        check("l512_last",   l_addr, 511);
        check("l512_n_wr",   n_wr, 512);
        check("l512_done",   d_rel, 517);
        check("l512_cycles", longint'(bus.cycles), CNT_EN ? 518 : 0);

        // Abort two cycles after the first write of a len=8 run.
        observe_run(8, D + 3, 0, n_rd, n_wr, f_rd, f_wr, d_rel, l_addr, l_busy);
        check("ab_n_wr",   n_wr, 3);
        check("ab_done",   d_rel, 0);
        check("ab_busy",   l_busy, D + 3);
        check("ab_cycles", longint'(bus.cycles), CNT_EN ? 518 : 0);

        // Start pulsed mid-run is ignored.
        observe_run(6, 0, 2, n_rd, n_wr, f_rd, f_wr, d_rel, l_addr, l_busy);
        check("sr_n_rd", n_rd, 6);
        check("sr_done", d_rel, 11);

        // Start coincident with abort in IDLE is ignored.
        bus.len = (AB+1)'(5); bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("sa_busy", longint'(bus.busy), 0);
        tick();
        check("sa_src_re", longint'(bus.src_re), 0);

        // Reset in DRAIN: outputs drop immediately, no done afterwards.
        bus.len = (AB+1)'(6); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        check("dr_in_drain", longint'(bus.dst_we), 1);
        aresetn = 1'b0;
        #1;
        check("dr_busy",   longint'(bus.busy), 0);
        check("dr_dst_we", longint'(bus.dst_we), 0);
        check("dr_cycles", longint'(bus.cycles), 0);
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (10) begin
            tick();
            check("dr_no_done", longint'(bus.done), 0);
        end

        // Randomized runs with stray starts and occasional aborts.
        for (int n = 0; n < 40; n++) begin
            wait_idle();
            l = ($urandom_range(0, 9) == 0) ? 512 : int'($urandom_range(0, 20));
            bus.len   = (AB+1)'(l);
            bus.start = 1'b1;
            bus.abort = ($urandom_range(0, 9) == 0);
            tick();
            for (int k = 0; k < l + D + 4 && k < 40; k++) begin
                bus.start = ($urandom_range(0, 5) == 0);
                bus.len   = (AB+1)'($urandom_range(0, 12));
                bus.abort = ($urandom_range(0, 39) == 0);
                tick();
            end
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        wait_idle();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eval_sram_to_sram_mul_seq.md
EVAL_SRAM_TO_SRAM_MUL_SEQ -- requirements
Module: eval_sram_to_sram_mul_seq

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 9, SRAM address width (512 entries).
REQ-002 SHALL have parameter RD_LATENCY, default 1, source SRAM read latency in cycles (>=1).
REQ-003 SHALL have parameter MUL_LATENCY, default 3, multiplier pipeline depth in cycles (>=0).
REQ-004 SHALL have parameter CNT_BITS, default 32, cycle-counter width.
REQ-005 SHALL have port aclk  input  1  single clock; all logic in this one domain.
REQ-006 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-008 SHALL have port abort  input  1  synchronous cancel of a run in progress.
REQ-009 SHALL have port len  input  ADDR_BITS+1  element count, sampled on accepted start.
REQ-010 SHALL have port busy  output  1  high from accepted start until done or abort.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port src_re  output  1  source SRAM read enable.
REQ-013 SHALL have port src_addr  output  ADDR_BITS  source SRAM read address.
REQ-014 SHALL have port dst_we  output  1  destination SRAM write enable (multiplier result valid).
REQ-015 SHALL have port dst_addr  output  ADDR_BITS  destination SRAM write address.
REQ-016 SHALL have port cycles  output  CNT_BITS  cycle count of last completed run.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 SHALL in IDLE accept start: len!=0 -> RUN, latch len, addr=0; len==0 -> DONE, no reads or writes.
REQ-019 SHALL ignore start when not in IDLE.
REQ-020 SHALL in RUN assert src_re with src_addr 0,1,...,len-1 on consecutive cycles, no gaps; move to DRAIN after the read at len-1.
REQ-021 SHALL delay src_re/src_addr through a RD_LATENCY+MUL_LATENCY stage shift register to produce dst_we/dst_addr; first dst_we exactly RD_LATENCY+MUL_LATENCY cycles after first src_re, dst_addr equal to the matching src_addr.
REQ-022 SHALL stay in DRAIN until the delay line is empty, then go to DONE in the cycle after the last dst_we.
REQ-023 SHALL in DONE pulse done for exactly one cycle, update cycles, return to IDLE; start is accepted again the next cycle.
REQ-024 SHALL hold busy high in RUN, DRAIN and DONE, low in IDLE.
REQ-025 SHALL on abort (any non-IDLE state) go to IDLE next cycle, clear the delay line (no further dst_we), no done pulse, cycles unchanged; abort in IDLE has no effect; abort wins over simultaneous start.
REQ-026 SHALL handle len = 2^ADDR_BITS (full SRAM): last address all-ones, no wrap, no extra read.
REQ-027 SHALL drive src_addr and dst_addr to 0 whenever their enables are low.

Reset
REQ-028 SHALL on aresetn low asynchronously force IDLE and clear the delay line, busy, done, src_re, src_addr, dst_we, dst_addr and cycles to 0.
REQ-029 SHALL on reset mid-run discard the run with no done pulse; after release behave as from power-up.

Configuration
REQ-030 SHALL compile cycle counter under macro EVAL_SEQ_CYCLE_COUNTER_EN: defined -> count cycles from accepted start to done inclusive and load cycles in DONE; undefined -> no counter logic, cycles tied to 0.

Verification
REQ-031 SHALL cover: len=4, RD_LATENCY=1, MUL_LATENCY=3 -> src_addr 0..3 on cycles 1..4 after start, dst_we addr 0..3 on cycles 5..8, done on cycle 9, cycles=10 (macro defined).
REQ-032 SHALL cover: len=0 start -> done the cycle after start, no src_re or dst_we, busy high for that one cycle only.
REQ-033 SHALL cover: len=512 -> 512 contiguous reads, last src_addr=511, exactly 512 dst_we, no address wrap.
REQ-034 SHALL cover: abort two cycles after first dst_we of len=8 run -> dst_we low from next cycle, no done, busy low, cycles keeps previous value.
REQ-035 SHALL cover: start pulsed during RUN and coincident with abort -> both ignored; aresetn low mid-DRAIN -> all outputs 0 immediately, no done.
REQ-036 SHALL cover: macro undefined build of REQ-031 stimulus -> identical SRAM traffic and done timing, cycles=0.
